// File: rtl/obstacle_pkg.sv
// obstacle_pkg: obstacle type encodings, y levels and the rand-to-obstacle mapping shared with the renderers
package obstacle_pkg;
    typedef enum logic [1:0] {
        OBS_IDLE   = 2'd0,
        OBS_AIR    = 2'd1,
        OBS_CACTUS = 2'd2,
        OBS_ROCK   = 2'd3
    } obs_type_t;

    typedef enum logic [1:0] {
        LVL_HIGH = 2'd0,
        LVL_MID  = 2'd1,
        LVL_LOW  = 2'd2
    } obs_lvl_t;

    typedef struct packed {
        obs_type_t typ;
        obs_lvl_t  lvl;
    } obs_pick_t;

    localparam int OBS_HIGH_Y = 160;
    localparam int OBS_MID_Y  = 200;
    localparam int OBS_LOW_Y  = 247;

    // rand % 6: 0 high air, 1 mid air, 2-3 cactus, 4-5 rock
    function automatic obs_pick_t obs_pick(input logic [12:0] r);
        obs_pick_t p;
        logic [2:0] m;
        m     = 3'(r % 13'd6);
        p.typ = m < 3'd2 ? OBS_AIR : m < 3'd4 ? OBS_CACTUS : OBS_ROCK;
        p.lvl = m == 3'd0 ? LVL_HIGH : m == 3'd1 ? LVL_MID : LVL_LOW;
        return p;
    endfunction
endpackage

// File: rtl/obstacle_slot.sv
// obstacle_slot: one obstacle's busy/type/x/y state with allocate, move and retire
module obstacle_slot
    import obstacle_pkg::*;
#(
    parameter int XW        = 10,
    parameter int SPAWN_X   = 780,
    parameter int DESPAWN_X = 80,
    parameter int LOW_Y     = OBS_LOW_Y
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          clear,
    input  logic          run,
    input  logic          alloc,
    input  obs_type_t     alloc_type,
    input  logic [XW-1:0] alloc_y,
    input  logic          move,
    output logic          busy,
    output logic [1:0]    typ,
    output logic [XW-1:0] x,
    output logic [XW-1:0] y,
    output logic          retire
);
    assign retire = run & busy & (x <= XW'(DESPAWN_X));

    // retire beats move; alloc only ever targets an idle slot so it never meets retire
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy <= 1'b0;
            typ  <= OBS_IDLE;
            x    <= XW'(SPAWN_X);
            y    <= XW'(LOW_Y);
        end else if (clear) begin
            busy <= 1'b0;
            typ  <= OBS_IDLE;
            x    <= XW'(SPAWN_X);
            y    <= XW'(LOW_Y);
        end else if (retire) begin
            busy <= 1'b0;
            typ  <= OBS_IDLE;
            x    <= XW'(SPAWN_X);
        end else if (run & alloc) begin
            busy <= 1'b1;
            typ  <= alloc_type;
            x    <= XW'(SPAWN_X);
            y    <= alloc_y;
        end else if (run & move & busy) begin
            x <= x - XW'(1);
        end
    end
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: spawns, moves and retires a pool of scrolling obstacles, ramps speed and keeps score
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int NUM_SLOTS  = 3,
    parameter int XW         = 10,
    parameter int SPAWN_X    = 780,
    parameter int DESPAWN_X  = 80,
    parameter int HIGH_Y     = OBS_HIGH_Y,
    parameter int MID_Y      = OBS_MID_Y,
    parameter int LOW_Y      = OBS_LOW_Y,
    parameter int SPEED_INIT = 200,
    parameter int SPEED_STEP = 20,
    parameter int SPEED_MIN  = 40,
    parameter int RAMP_TICKS = 180
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    run,
    input  logic                    clear,
    input  logic                    spawn_tick,
    input  logic                    move_tick,
    input  logic                    ramp_tick,
    input  logic [12:0]             rand_val,
    output logic [NUM_SLOTS-1:0]    slot_busy,
    output logic [2*NUM_SLOTS-1:0]  slot_type,
    output logic [XW*NUM_SLOTS-1:0] slot_x,
    output logic [XW*NUM_SLOTS-1:0] slot_y,
    output logic [7:0]              speed,
    output logic                    spawned,
    output logic [15:0]             score
);
    localparam int RW = $clog2(RAMP_TICKS + 1);

    logic [7:0]           spawn_cnt;
    logic [7:0]           move_cnt;
    logic [RW-1:0]        ramp_cnt;
    logic [NUM_SLOTS-1:0] retire_v;
    logic [NUM_SLOTS-1:0] alloc_v;
    logic                 alloc_any;
    logic                 spawn_due;
    logic                 move_due;
    logic                 ramp_due;
    logic [3:0]           ret_n;
    logic [16:0]          score_sum;
    obs_pick_t            pick;
    logic [XW-1:0]        pick_y;

    assign pick      = obs_pick(rand_val);
    assign pick_y    = pick.lvl == LVL_HIGH ? XW'(HIGH_Y) : pick.lvl == LVL_MID ? XW'(MID_Y) : XW'(LOW_Y);
    assign spawn_due = run & spawn_tick & ~(spawn_cnt < speed);
    assign move_due  = run & move_tick & ~(move_cnt < speed);
    assign ramp_due  = run & ramp_tick & (ramp_cnt == RW'(RAMP_TICKS - 1));
    assign alloc_any = |alloc_v;
    assign score_sum = {1'b0, score} + 17'(ret_n);

    // lowest-index idle slot wins; retiring slots are still busy so they are never picked
    always_comb begin
        alloc_v = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) alloc_v = slot_busy[i] ? alloc_v : NUM_SLOTS'(1) << i;
        alloc_v = spawn_due ? alloc_v : '0;
    end

    // number of slots retiring this cycle
    always_comb begin
        ret_n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) ret_n = ret_n + 4'(retire_v[i]);
    end

    // cadence counters, speed ramp and score; spawn_cnt holds when the pool is full
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            spawn_cnt <= '0;
            move_cnt  <= '0;
            ramp_cnt  <= '0;
            speed     <= 8'(SPEED_INIT);
            spawned   <= 1'b0;
            score     <= '0;
        end else if (clear) begin
            spawn_cnt <= '0;
            move_cnt  <= '0;
            ramp_cnt  <= '0;
            speed     <= 8'(SPEED_INIT);
            spawned   <= 1'b0;
            score     <= '0;
        end else if (run) begin
            if (spawn_tick) spawn_cnt <= spawn_cnt < speed ? spawn_cnt + 8'd1 : alloc_any ? 8'd0 : spawn_cnt;
            if (move_tick) move_cnt <= move_cnt < speed ? move_cnt + 8'd1 : 8'd0;
            if (ramp_tick) ramp_cnt <= ramp_due ? '0 : ramp_cnt + RW'(1);
            if (ramp_due) speed <= int'(speed) >= SPEED_MIN + SPEED_STEP ? speed - 8'(SPEED_STEP) : 8'(SPEED_MIN);
            score   <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            spawned <= alloc_any;
        end else begin
            spawned <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        obstacle_slot #(
            .XW        (XW),
            .SPAWN_X   (SPAWN_X),
            .DESPAWN_X (DESPAWN_X),
            .LOW_Y     (LOW_Y)
        ) u_slot (
            .CLK        (CLK),
            .RESET      (RESET),
            .clear      (clear),
            .run        (run),
            .alloc      (alloc_v[g]),
            .alloc_type (pick.typ),
            .alloc_y    (pick_y),
            .move       (move_due),
            .busy       (slot_busy[g]),
            .typ        (slot_type[2*g +: 2]),
            .x          (slot_x[XW*g +: XW]),
            .y          (slot_y[XW*g +: XW]),
            .retire     (retire_v[g])
        );
    end
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: table-driven, directed and random checks against a slot-array reference model
module tb_obstacle_scheduler;
    localparam int N = 3;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          run = 1'b0;
    logic          clear = 1'b0;
    logic          spawn_tick = 1'b0;
    logic          move_tick = 1'b0;
    logic          ramp_tick = 1'b0;
    logic [12:0]   rand_val = '0;
    logic [N-1:0]  slot_busy;
    logic [2*N-1:0] slot_type;
    logic [10*N-1:0] slot_x;
    logic [10*N-1:0] slot_y;
    logic [7:0]    speed;
    logic          spawned;
    logic [15:0]   score;

    int checks = 0;
    int errors = 0;

    obstacle_scheduler dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .run        (run),
        .clear      (clear),
        .spawn_tick (spawn_tick),
        .move_tick  (move_tick),
        .ramp_tick  (ramp_tick),
        .rand_val   (rand_val),
        .slot_busy  (slot_busy),
        .slot_type  (slot_type),
        .slot_x     (slot_x),
        .slot_y     (slot_y),
        .speed      (speed),
        .spawned    (spawned),
        .score      (score)
    );

    always #5 CLK = ~CLK;

    // reference model: per-slot arrays and counters stepped from the behavioural rules
    int m_busy[N], m_type[N], m_x[N], m_y[N];
    int m_speed, m_score, m_sc, m_mc, m_rc, m_spawned;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_type[i] = 0; m_x[i] = 780; m_y[i] = 247;
        end
        m_speed = 200; m_score = 0; m_sc = 0; m_mc = 0; m_rc = 0; m_spawned = 0;
    endtask

    task automatic m_step();
        int ret[N];
        int alloc, nret, mv, r;
        alloc = -1; nret = 0; mv = 0;
        for (int i = 0; i < N; i++) ret[i] = (m_busy[i] != 0 && m_x[i] <= 80) ? 1 : 0;
        if (spawn_tick) begin
            if (m_sc < m_speed) m_sc++;
            else begin
                for (int i = 0; i < N && alloc < 0; i++) if (m_busy[i] == 0) alloc = i;
                if (alloc >= 0) m_sc = 0;
            end
        end
        if (move_tick) begin
            if (m_mc < m_speed) m_mc++;
            else begin m_mc = 0; mv = 1; end
        end
        if (ramp_tick) begin
            if (m_rc == 179) begin
                m_rc = 0;
                m_speed = (m_speed - 20 < 40) ? 40 : m_speed - 20;
            end else m_rc++;
        end
        r = int'(rand_val) % 6;
        for (int i = 0; i < N; i++) begin
            if (ret[i] != 0) begin
                m_busy[i] = 0; m_type[i] = 0; m_x[i] = 780; nret++;
            end else if (i == alloc) begin
                m_busy[i] = 1; m_type[i] = r / 2 + 1; m_x[i] = 780;
                m_y[i] = (r == 0) ? 160 : (r == 1) ? 200 : 247;
            end else if (mv != 0 && m_busy[i] != 0) m_x[i]--;
        end
        m_score = (m_score + nret > 65535) ? 65535 : m_score + nret;
        m_spawned = (alloc >= 0) ? 1 : 0;
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) m_reset();
        else if (clear) m_reset();
        else if (run) m_step();
        else m_spawned = 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic [N-1:0] eb;
        logic [2*N-1:0] et;
        logic [10*N-1:0] ex, ey;
        for (int i = 0; i < N; i++) begin
            eb[i] = m_busy[i][0];
            et[2*i +: 2] = m_type[i][1:0];
            ex[10*i +: 10] = m_x[i][9:0];
            ey[10*i +: 10] = m_y[i][9:0];
        end
        chk("model_busy", slot_busy, eb);
        chk("model_type", slot_type, et);
        chk("model_x", slot_x, ex);
        chk("model_y", slot_y, ey);
        chk("model_speed", speed, m_speed);
        chk("model_spawned", spawned, m_spawned);
        chk("model_score", score, m_score);
    endtask

    task automatic chk_reset_vals(input string nm);
        logic [10*N-1:0] rx, ry;
        for (int i = 0; i < N; i++) begin
            rx[10*i +: 10] = 10'd780;
            ry[10*i +: 10] = 10'd247;
        end
        chk({nm, "_busy"}, slot_busy, 0);
        chk({nm, "_type"}, slot_type, 0);
        chk({nm, "_x"}, slot_x, rx);
        chk({nm, "_y"}, slot_y, ry);
        chk({nm, "_speed"}, speed, 200);
        chk({nm, "_spawned"}, spawned, 0);
        chk({nm, "_score"}, score, 0);
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
        cmp_all();
    endtask

    task automatic drive(input logic r, input logic c, input logic st, input logic mt, input logic rt);
        run = r; clear = c; spawn_tick = st; move_tick = mt; ramp_tick = rt;
    endtask

    typedef struct {
        logic [12:0] r;
        int          t;
        int          y;
    } vec_t;

    vec_t tab[9];

    initial begin
        int n;
        tab[0] = '{13'd2, 2, 247};
        tab[1] = '{13'd0, 1, 160};
        tab[2] = '{13'd1, 1, 200};
        tab[3] = '{13'd3, 2, 247};
        tab[4] = '{13'd4, 3, 247};
        tab[5] = '{13'd5, 3, 247};
        tab[6] = '{13'd6, 1, 160};
        tab[7] = '{13'd8191, 1, 200};
        tab[8] = '{13'd11, 3, 247};

        #1 RESET = 1'b1;
        #1 chk_reset_vals("reset");
        @(negedge CLK);
        cyc();
        RESET = 1'b0;
        cyc();

        // rand -> type/y mapping: each entry allocates slot0 after speed+1 spawn ticks
        for (int k = 0; k < 9; k++) begin
            drive(1, 1, 0, 0, 0);
            cyc();
            drive(1, 0, 1, 0, 0);
            rand_val = tab[k].r;
            repeat (200) cyc();
            chk("tab_not_yet", slot_busy, 0);
            cyc();
            chk("tab_busy", slot_busy, 1);
            chk("tab_type", slot_type[1:0], tab[k].t);
            chk("tab_y", slot_y[9:0], tab[k].y);
            chk("tab_x", slot_x[9:0], 780);
            chk("tab_spawned", spawned, 1);
            spawn_tick = 1'b0;
            cyc();
            chk("tab_spawned_once", spawned, 0);
        end

        // speed ramp down to the floor, then hold
        drive(1, 1, 0, 0, 0);
        cyc();
        drive(1, 0, 0, 0, 1);
        for (int k = 1; k <= 1640; k++) begin
            cyc();
            if (k == 179) chk("ramp_before", speed, 200);
            if (k == 180) chk("ramp_first", speed, 180);
            if (k == 360) chk("ramp_second", speed, 160);
            if (k == 1440) chk("ramp_floor", speed, 40);
        end
        chk("ramp_no_wrap", speed, 40);

        // fill the pool at speed 40
        drive(1, 0, 1, 0, 0);
        rand_val = 13'd0;
        repeat (41) cyc();
        chk("fill0_busy", slot_busy, 3'b001);
        chk("fill0_type", slot_type[1:0], 1);
        chk("fill0_y", slot_y[9:0], 160);
        rand_val = 13'd1;
        repeat (41) cyc();
        chk("fill1_busy", slot_busy, 3'b011);
        chk("fill1_type", slot_type[3:2], 1);
        chk("fill1_y", slot_y[19:10], 200);
        rand_val = 13'd4;
        move_tick = 1'b1;
        repeat (41) cyc();
        chk("fill2_busy", slot_busy, 3'b111);
        chk("fill2_type", slot_type[5:4], 3);
        chk("fill2_y", slot_y[29:20], 247);

        // slots 0 and 1 reach the left edge together; full pool keeps refusing spawns
        n = 0;
        while (m_busy[0] != 0 && n < 30000) begin
            cyc();
            n++;
        end
        chk("retire_timeout", (n < 30000) ? 1 : 0, 1);
        chk("retire_score2", score, 2);
        chk("retire_busy", slot_busy, 3'b100);
        chk("retire_no_alloc", spawned, 0);
        chk("retire_x0", slot_x[9:0], 780);
        rand_val = 13'd5;
        cyc();
        chk("realloc_busy", slot_busy, 3'b101);
        chk("realloc_spawned", spawned, 1);
        chk("realloc_type", slot_type[1:0], 3);
        move_tick = 1'b0;
        rand_val = 13'd2;
        repeat (41) cyc();
        chk("refill_busy", slot_busy, 3'b111);

        // clear mid-game
        drive(1, 1, 0, 0, 0);
        cyc();
        chk_reset_vals("clear");
        clear = 1'b0;

        // asynchronous reset mid-move
        drive(1, 0, 1, 0, 1);
        rand_val = 13'd3;
        repeat (250) cyc();
        chk("pre_reset_speed", speed, 180);
        chk("pre_reset_busy", slot_busy, 1);
        drive(1, 0, 0, 1, 0);
        repeat (5) cyc();
        #2 RESET = 1'b1;
        #1 chk_reset_vals("async_reset");
        @(negedge CLK);
        RESET = 1'b0;
        cyc();

        // random mix against the model
        for (int k = 0; k < 8000; k++) begin
            run        = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 299) == 0);
            spawn_tick = $urandom_range(0, 1) == 1;
            move_tick  = $urandom_range(0, 1) == 1;
            ramp_tick  = $urandom_range(0, 1) == 1;
            rand_val   = 13'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
